// File: rtl/core_io_axi.sv
// core_io_axi: AXI4-Lite master that runs the core's IN/OUT instructions.
// Define IO_STATUS_POLL_EN to poll the UART status register before each access.
module core_io_axi #(
    parameter logic [3:0] RX_ADDR      = 4'h0,
    parameter logic [3:0] TX_ADDR      = 4'h4,
    parameter logic [3:0] STAT_ADDR    = 4'h8,
    parameter int         RX_VALID_BIT = 0,
    parameter int         TX_FULL_BIT  = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_IN,
    input  logic        REQ_OUT,
    input  logic [31:0] OUT_DATA,
    output logic [31:0] IN_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [3:0]  S_AXI_AWADDR,
    output logic        S_AXI_AWVALID,
    input  logic        S_AXI_AWREADY,
    output logic [31:0] S_AXI_WDATA,
    output logic [3:0]  S_AXI_WSTB,
    output logic        S_AXI_WVALID,
    input  logic        S_AXI_WREADY,
    input  logic [1:0]  S_AXI_BRESP,
    input  logic        S_AXI_BVALID,
    output logic        S_AXI_BREADY,
    output logic [3:0]  S_AXI_ARADDR,
    output logic        S_AXI_ARVALID,
    input  logic        S_AXI_ARREADY,
    input  logic [31:0] S_AXI_RDATA,
    input  logic [1:0]  S_AXI_RRESP,
    input  logic        S_AXI_RVALID,
    output logic        S_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef IO_STATUS_POLL_EN
        ST_AR,
        ST_R,
`endif
        DAT_AR,
        DAT_R,
        TX_AW,
        TX_B,
        FIN
    } state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] in_data_q, in_data_d;
    logic [3:0]  araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [3:0]  awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstb_q, wstb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
`ifdef IO_STATUS_POLL_EN
    logic        is_out_q, is_out_d;
    logic [7:0]  byte_q, byte_d;
    logic        stat_wait;
    logic        unused_ok;
    assign unused_ok = ^{OUT_DATA[31:8], S_AXI_RDATA[31:8]};
`else
    logic        unused_ok;
    assign unused_ok = ^{OUT_DATA[31:8], S_AXI_RDATA[31:8],
                         (STAT_ADDR == 4'h0),
                         (RX_VALID_BIT == TX_FULL_BIT)};
`endif

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        in_data_d = in_data_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstb_d    = wstb_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
`ifdef IO_STATUS_POLL_EN
        is_out_d  = is_out_q;
        byte_d    = byte_q;
        stat_wait = is_out_q ? S_AXI_RDATA[TX_FULL_BIT]
                             : !S_AXI_RDATA[RX_VALID_BIT];
`endif
        unique case (state_q)
            IDLE: begin
                if (REQ_OUT || REQ_IN) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
`ifdef IO_STATUS_POLL_EN
                    is_out_d  = REQ_OUT;
                    byte_d    = OUT_DATA[7:0];
                    state_d   = ST_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = STAT_ADDR;
`else
                    if (REQ_OUT) begin
                        state_d   = TX_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = TX_ADDR;
                        wdata_d   = {24'b0, OUT_DATA[7:0]};
                        wstb_d    = 4'b0001;
                    end else begin
                        state_d   = DAT_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = RX_ADDR;
                    end
`endif
                end
            end
`ifdef IO_STATUS_POLL_EN
            ST_AR: begin
                if (S_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (S_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (S_AXI_RRESP != 2'b00) err_d = 1'b1;
                    if (stat_wait) begin
                        state_d   = ST_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = STAT_ADDR;
                    end else if (is_out_q) begin
                        state_d   = TX_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = TX_ADDR;
                        wdata_d   = {24'b0, byte_q};
                        wstb_d    = 4'b0001;
                    end else begin
                        state_d   = DAT_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = RX_ADDR;
                    end
                end
            end
`endif
            DAT_AR: begin
                if (S_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DAT_R;
                end
            end
            DAT_R: begin
                if (S_AXI_RVALID) begin
                    rready_d  = 1'b0;
                    in_data_d = {24'b0, S_AXI_RDATA[7:0]};
                    if (S_AXI_RRESP != 2'b00) err_d = 1'b1;
                    state_d   = FIN;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            TX_AW: begin
                if (S_AXI_AWREADY) awvalid_d = 1'b0;
                if (S_AXI_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || S_AXI_AWREADY) &&
                    (!wvalid_q || S_AXI_WREADY)) begin
                    bready_d = 1'b1;
                    state_d  = TX_B;
                end
            end
            TX_B: begin
                if (S_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (S_AXI_BRESP != 2'b00) err_d = 1'b1;
                    state_d  = FIN;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            in_data_q <= 32'b0;
            araddr_q  <= 4'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= 4'b0;
            awvalid_q <= 1'b0;
            wdata_q   <= 32'b0;
            wstb_q    <= 4'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`ifdef IO_STATUS_POLL_EN
            is_out_q  <= 1'b0;
            byte_q    <= 8'b0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            in_data_q <= in_data_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstb_q    <= wstb_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
`ifdef IO_STATUS_POLL_EN
            is_out_q  <= is_out_d;
            byte_q    <= byte_d;
`endif
        end
    end

    assign IN_DATA       = in_data_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign S_AXI_ARADDR  = araddr_q;
    assign S_AXI_ARVALID = arvalid_q;
    assign S_AXI_RREADY  = rready_q;
    assign S_AXI_AWADDR  = awaddr_q;
    assign S_AXI_AWVALID = awvalid_q;
    assign S_AXI_WDATA   = wdata_q;
    assign S_AXI_WSTB    = wstb_q;
    assign S_AXI_WVALID  = wvalid_q;
    assign S_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_core_io_axi.sv
// tb_core_io_axi: directed + random IN/OUT transactions against a
// reactive AXI4-Lite UART slave and a cycle-count reference model.
module tb_core_io_axi;

`ifdef IO_STATUS_POLL_EN
    localparam int POLL = 1;
`else
    localparam int POLL = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_IN = 1'b0;
    logic        REQ_OUT = 1'b0;
    logic [31:0] OUT_DATA = 32'b0;
    logic [31:0] IN_DATA;
    logic        BUSY, DONE, ERR;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;

    core_io_axi dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_IN(REQ_IN), .REQ_OUT(REQ_OUT), .OUT_DATA(OUT_DATA),
        .IN_DATA(IN_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTB(S_AXI_WSTB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // slave configuration, owned by the stimulus block
    int          aw_wait = 0, w_wait = 0, stat_n = 0, stat_base = 0;
    logic [1:0]  rresp_stat = 2'b00, rresp_rx = 2'b00, bresp_cfg = 2'b00;
    logic [31:0] rx_word = 32'b0, stat_bad = 32'b0, stat_ok = 32'b0;

    // slave state and monitor counters
    int   aw_cnt = 0, w_cnt = 0;
    bit   aw_got = 0, w_got = 0;
    int   stat_rd = 0, rx_rd = 0, aw_hs = 0, b_hs = 0;
    int   awv_cyc = 0, wv_cyc = 0, done_cnt = 0, stab_viol = 0;
    logic [3:0]  last_awaddr = 4'b0, last_wstb = 4'b0;
    logic [31:0] last_wdata = 32'b0;
    bit   ar_pend = 0, aw_pend = 0, w_pend = 0;
    logic [3:0]  ar_p = 4'b0, aw_p = 4'b0, wstb_p = 4'b0;
    logic [31:0] wdata_p = 32'b0;

    assign S_AXI_ARREADY = 1'b1;
    assign S_AXI_AWREADY = S_AXI_AWVALID && (aw_cnt >= aw_wait);
    assign S_AXI_WREADY  = S_AXI_WVALID && (w_cnt >= w_wait);

    // reactive UART-style slave
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= 32'b0;
            S_AXI_RRESP  <= 2'b00;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            aw_cnt <= 0;
            w_cnt  <= 0;
            aw_got <= 0;
            w_got  <= 0;
        end else begin
            if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                if (S_AXI_ARADDR == 4'h8) begin
                    S_AXI_RDATA <= ((stat_rd - stat_base) < stat_n) ? stat_bad : stat_ok;
                    S_AXI_RRESP <= rresp_stat;
                    stat_rd <= stat_rd + 1;
                end else begin
                    S_AXI_RDATA <= rx_word;
                    S_AXI_RRESP <= rresp_rx;
                    rx_rd <= rx_rd + 1;
                end
            end
            if (S_AXI_AWVALID && !S_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (S_AXI_WVALID && !S_AXI_WREADY) w_cnt <= w_cnt + 1;
            else w_cnt <= 0;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_hs <= aw_hs + 1;
                last_awaddr <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                last_wdata <= S_AXI_WDATA;
                last_wstb  <= S_AXI_WSTB;
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
                b_hs <= b_hs + 1;
            end
            if ((aw_got || (S_AXI_AWVALID && S_AXI_AWREADY)) &&
                (w_got || (S_AXI_WVALID && S_AXI_WREADY))) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= bresp_cfg;
                aw_got <= 0;
                w_got  <= 0;
            end else begin
                if (S_AXI_AWVALID && S_AXI_AWREADY) aw_got <= 1;
                if (S_AXI_WVALID && S_AXI_WREADY) w_got <= 1;
            end
        end
    end

    // cycle counters and VALID/payload hold monitor
    always @(posedge CLK) begin
        if (S_AXI_AWVALID) awv_cyc <= awv_cyc + 1;
        if (S_AXI_WVALID) wv_cyc <= wv_cyc + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (RST_N) begin
            if ((ar_pend && (!S_AXI_ARVALID || S_AXI_ARADDR != ar_p)) ||
                (aw_pend && (!S_AXI_AWVALID || S_AXI_AWADDR != aw_p)) ||
                (w_pend && (!S_AXI_WVALID || S_AXI_WDATA != wdata_p ||
                            S_AXI_WSTB != wstb_p)))
                stab_viol <= stab_viol + 1;
        end
        ar_pend <= RST_N && S_AXI_ARVALID && !S_AXI_ARREADY;
        aw_pend <= RST_N && S_AXI_AWVALID && !S_AXI_AWREADY;
        w_pend  <= RST_N && S_AXI_WVALID && !S_AXI_WREADY;
        ar_p    <= S_AXI_ARADDR;
        aw_p    <= S_AXI_AWADDR;
        wdata_p <= S_AXI_WDATA;
        wstb_p  <= S_AXI_WSTB;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; lat is the DONE cycle counting the accept cycle as 1.
    task automatic run(input bit o, input bit i, input logic [31:0] d,
                       output int lat, output logic err_at_done);
        bit seen;
        seen = 0;
        lat = 0;
        err_at_done = 1'bx;
        @(negedge CLK);
        REQ_OUT = o;
        REQ_IN = i;
        OUT_DATA = d;
        @(posedge CLK);
        #1;
        REQ_OUT = 0;
        REQ_IN = 0;
        check("busy_after_accept", BUSY, 1);
        for (int k = 3; k <= 400 && !seen; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                seen = 1;
                lat = k;
                err_at_done = ERR;
            end
        end
        check("done_seen", seen, 1);
        check("busy_low_at_done", BUSY, 0);
        @(posedge CLK);
        #1;
        check("done_one_cycle", DONE, 0);
    endtask

    function automatic logic [83:0] all_outs();
        return {IN_DATA, BUSY, DONE, ERR, S_AXI_AWADDR, S_AXI_AWVALID,
                S_AXI_WDATA, S_AXI_WSTB, S_AXI_WVALID, S_AXI_BREADY,
                S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY};
    endfunction

    initial begin
        int lat, exp_lat, aw0, b0, rx0, st0, awc0, wc0, dn0, mx, sn;
        logic e;
        logic [31:0] exp_in, d;
        bit o, seen;

        exp_in = 32'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", all_outs(), 84'b0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_outputs", all_outs(), 84'b0);

        // OUT, zero-wait slave, status 0
        stat_n = 0; stat_ok = 32'h0; stat_base = stat_rd;
        aw0 = aw_hs; st0 = stat_rd; b0 = b_hs;
        run(1, 0, 32'h12345641, lat, e);
        check("out_latency", lat, 4 + 2 * POLL);
        check("out_aw_count", aw_hs - aw0, 1);
        check("out_b_count", b_hs - b0, 1);
        check("out_awaddr", last_awaddr, 4'h4);
        check("out_wdata", last_wdata, 32'h00000041);
        check("out_wstb", last_wstb, 4'b0001);
        check("out_err", e, 0);
        check("out_stat_reads", stat_rd - st0, POLL);

        // IN after three not-ready status reads
        stat_n = 3; stat_bad = 32'h0; stat_ok = 32'h1; stat_base = stat_rd;
        rx_word = 32'hFFFFFF5A;
        st0 = stat_rd; dn0 = done_cnt;
        run(0, 1, 32'h0, lat, e);
        exp_in = 32'h0000005A;
        check("in_stat_reads", stat_rd - st0, 4 * POLL);
        check("in_data", IN_DATA, exp_in);
        check("in_done_count", done_cnt - dn0, 1);
        check("in_latency", lat, 4 + 2 * POLL * 4);

        // OUT with delayed AWREADY / WREADY
        stat_n = 0; stat_base = stat_rd;
        aw_wait = 1; w_wait = 4;
        awc0 = awv_cyc; wc0 = wv_cyc; b0 = b_hs;
        run(1, 0, 32'hA5A5A5C3, lat, e);
        check("split_awvalid_cycles", awv_cyc - awc0, 2);
        check("split_wvalid_cycles", wv_cyc - wc0, 5);
        check("split_b_count", b_hs - b0, 1);
        check("split_latency", lat, 8 + 2 * POLL);
        check("split_wdata", last_wdata, 32'h000000C3);
        aw_wait = 0; w_wait = 0;

        // IN with SLVERR on data read, then clean OUT
        stat_ok = 32'h1; stat_base = stat_rd;
        rx_word = 32'h00000077; rresp_rx = 2'b10;
        run(0, 1, 32'h0, lat, e);
        exp_in = 32'h00000077;
        check("slverr_err", e, 1);
        check("slverr_in_data", IN_DATA, exp_in);
        rresp_rx = 2'b00; stat_ok = 32'h0; stat_base = stat_rd;
        run(1, 0, 32'h00000099, lat, e);
        check("err_cleared", e, 0);

        // async reset while in TX_B with BVALID pending
        stat_base = stat_rd; b0 = b_hs;
        @(negedge CLK);
        REQ_OUT = 1; OUT_DATA = 32'h0000003C;
        @(posedge CLK);
        #1;
        REQ_OUT = 0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (S_AXI_BREADY && S_AXI_BVALID) seen = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        check("reached_tx_b", seen, 1);
        #2 RST_N = 1'b0;
        #1;
        check("midreset_outputs", all_outs(), 84'b0);
        exp_in = 32'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("aborted_b_not_done", b_hs - b0, 0);
        stat_ok = 32'h1; stat_base = stat_rd; rx_word = 32'h12345681;
        run(0, 1, 32'h0, lat, e);
        exp_in = 32'h00000081;
        check("post_reset_in_data", IN_DATA, exp_in);
        check("post_reset_err", e, 0);

        // both requests together: OUT wins
        stat_ok = 32'h0; stat_base = stat_rd;
        aw0 = aw_hs; rx0 = rx_rd;
        run(1, 1, 32'h000000E7, lat, e);
        check("both_aw_count", aw_hs - aw0, 1);
        check("both_no_rx_read", rx_rd - rx0, 0);
        check("both_in_data_kept", IN_DATA, exp_in);
        check("both_wdata", last_wdata, 32'h000000E7);

        // randomized transactions against the cycle/data model
        for (int t = 0; t < 16; t++) begin
            o = 1'($urandom_range(0, 1));
            d = $urandom;
            sn = $urandom_range(0, 2);
            aw_wait = $urandom_range(0, 3);
            w_wait = $urandom_range(0, 3);
            rx_word = $urandom;
            rresp_rx = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            stat_bad = o ? ($urandom | 32'h8) : ($urandom & ~32'h1);
            stat_ok  = o ? ($urandom & ~32'h8) : ($urandom | 32'h1);
            stat_n = sn;
            stat_base = stat_rd;
            aw0 = aw_hs; rx0 = rx_rd; st0 = stat_rd;
            run(o, !o, d, lat, e);
            mx = (aw_wait > w_wait) ? aw_wait : w_wait;
            exp_lat = 4 + POLL * 2 * (sn + 1) + (o ? mx : 0);
            if (!o) exp_in = rx_word & 32'hFF;
            check("rnd_latency", lat, exp_lat);
            check("rnd_err", e, o ? (bresp_cfg != 2'b00) : (rresp_rx != 2'b00));
            check("rnd_in_data", IN_DATA, exp_in);
            check("rnd_aw_count", aw_hs - aw0, o ? 1 : 0);
            check("rnd_rx_count", rx_rd - rx0, o ? 0 : 1);
            check("rnd_stat_reads", stat_rd - st0, POLL * (sn + 1));
            if (o) check("rnd_wdata", last_wdata, d & 32'hFF);
        end
        check("valid_payload_stable", stab_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_io_axi.md
Name: core_io_axi

Overview:
- AXI4-Lite master that executes the core's IN/OUT instructions against a UART-Lite style peripheral.
- Sits directly downstream of the core's execute/writeback stages and drives the core's S_AXI_* port group.
- OUT sends the low byte of a register to the TX FIFO.
- IN waits for a received byte and returns it zero-extended for register writeback.
- The core stalls on BUSY and resumes on the DONE pulse.

Parameters:
RX_ADDR, 4'h0, RX FIFO register address
TX_ADDR, 4'h4, TX FIFO register address
STAT_ADDR, 4'h8, status register address
RX_VALID_BIT, 0, status bit set when RX FIFO is non-empty
TX_FULL_BIT, 3, status bit set when TX FIFO is full

Ports:
CLK  input  1  clock
RST_N  input  1  asynchronous active-low reset
REQ_IN  input  1  start IN transaction; sampled only in IDLE
REQ_OUT  input  1  start OUT transaction; sampled only in IDLE
OUT_DATA  input  32  rs1 value; bits [7:0] are transmitted
IN_DATA  output  32  received byte zero-extended; held until the next IN completes
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle completion pulse
ERR  output  1  valid with DONE; set when any xRESP != 2'b00 during the transaction
S_AXI_AWADDR  output  4  write address
S_AXI_AWVALID  output  1  write address valid
S_AXI_AWREADY  input  1  write address ready
S_AXI_WDATA  output  32  write data
S_AXI_WSTB  output  4  write strobe
S_AXI_WVALID  output  1  write data valid
S_AXI_WREADY  input  1  write data ready
S_AXI_BRESP  input  2  write response
S_AXI_BVALID  input  1  write response valid
S_AXI_BREADY  output  1  write response ready
S_AXI_ARADDR  output  4  read address
S_AXI_ARVALID  output  1  read address valid
S_AXI_ARREADY  input  1  read address ready
S_AXI_RDATA  input  32  read data
S_AXI_RRESP  input  2  read response
S_AXI_RVALID  input  1  read data valid
S_AXI_RREADY  output  1  read data ready

Behaviour:
- Reset (async, RST_N low): state IDLE. All outputs 0: every *VALID, BREADY, RREADY, BUSY, DONE, ERR, IN_DATA, every *ADDR, WDATA, WSTB.
- Reset mid-transaction: immediate return to IDLE; the aborted request is dropped and not replayed.
- All outputs are registered.
- States: IDLE, ST_AR, ST_R, DAT_AR, DAT_R, TX_AW, TX_B, FIN.
- IDLE:
  - REQ_OUT -> latch OUT_DATA[7:0], go to ST_AR.
  - REQ_IN -> go to ST_AR.
  - Both asserted together: OUT wins and REQ_IN is ignored.
  - BUSY is set the cycle after acceptance.
- ST_AR: ARADDR=STAT_ADDR, ARVALID=1. ARVALID is held until ARREADY is sampled high, then go to ST_R.
- ST_R: RREADY=1. On RVALID:
  - IN and status[RX_VALID_BIT]=0 -> back to ST_AR (poll).
  - OUT and status[TX_FULL_BIT]=1 -> back to ST_AR (poll).
  - Otherwise: IN -> DAT_AR; OUT -> TX_AW.
  - Polling has no timeout.
- DAT_AR: ARADDR=RX_ADDR, ARVALID held until ARREADY. DAT_R: RREADY=1; on RVALID, IN_DATA <= {24'b0, RDATA[7:0]}, then go to FIN.
- TX_AW:
  - AWVALID and WVALID rise in the same cycle. AWADDR=TX_ADDR, WDATA={24'b0, byte}, WSTB=4'b0001.
  - Each VALID drops independently once its READY is sampled high, including same-cycle acceptance.
  - Go to TX_B only when both are accepted.
- TX_B: BREADY=1; on BVALID go to FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=0 in the same cycle, then IDLE. A new request is accepted no earlier than the cycle after FIN.
- ERR: sticky over the transaction, output with DONE, cleared on the next acceptance.
- An erroring status read still proceeds using the returned data.
- Best-case latency: OUT = 6 cycles (acceptance to DONE) with zero-wait slaves; IN = 6 cycles.
- The ARADDR/AWADDR/WDATA payload is stable while the corresponding VALID is high.

Optional Feature:
- Macro IO_STATUS_POLL_EN.
- Defined: status polling as described above.
- Undefined: ST_AR/ST_R are removed. IDLE goes directly to DAT_AR (IN) or TX_AW (OUT), and the peripheral's own flow control is relied on.
- Undefined latency: IN = 4 cycles, OUT = 4 cycles.

Test Plan:
- REQ_OUT, OUT_DATA=32'h12345641, zero-wait slave, status=0 -> one AW at 4'h4, WDATA=32'h00000041, WSTB=4'b0001; DONE 6 cycles after acceptance; ERR=0.
- REQ_IN, status reads 0 three times then 1, RX returns 32'hFFFFFF5A -> four status reads observed; IN_DATA=32'h0000005A; single DONE pulse.
- OUT with AWREADY at cycle+1 and WREADY at cycle+4 -> AWVALID drops after its accept, WVALID stays high until cycle+4; exactly one B handshake.
- IN with RRESP=2'b10 on the RX read -> DONE with ERR=1; next OUT with OKAY responses -> ERR=0.
- RST_N low during TX_B with BVALID pending -> all outputs 0 asynchronously; after release, REQ_IN completes normally.
- REQ_IN and REQ_OUT asserted in the same cycle -> only the write transaction occurs; IN_DATA unchanged.
